// File: rtl/memory_access_unit.sv
// Load/store initiator between the CPU datapath and a byte-addressed 64-bit RAM.
// Partial stores read the surrounding doubleword first, because the RAM always writes 8 bytes.
module memory_access_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic [63:0] memory_address,
    output logic [63:0] write_data,
    output logic        memory_write,
    output logic        memory_read,
    input  logic [63:0] read_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        write_q;

    logic [63:0] keep_mask;
    logic        sign_bit;
    logic [63:0] load_value;

    // keep_mask selects the low 2^size_q bytes that belong to the request.
    // NOTE: every always_comb output gets a default before any branch, so no latch can form.
    always_comb begin
        keep_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        sign_bit  = 1'b0;
        case (size_q)
            2'd0: begin keep_mask = 64'h0000_0000_0000_00FF; sign_bit = read_data[7];  end
            2'd1: begin keep_mask = 64'h0000_0000_0000_FFFF; sign_bit = read_data[15]; end
            2'd2: begin keep_mask = 64'h0000_0000_FFFF_FFFF; sign_bit = read_data[31]; end
            default: ;
        endcase
        load_value = read_data & keep_mask;
        if (signed_q && sign_bit) begin
            load_value = load_value | ~keep_mask;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race readers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        write_q  <= req_write;
                        state    <= (req_write && req_size == 2'd3) ? WRITE : READ;
                    end
                end
                READ: begin
                    if (write_q) begin
                        wdata_q <= (read_data & ~keep_mask) | (wdata_q & keep_mask);
                        state   <= WRITE;
                    end else begin
                        rdata_q <= load_value;
                        state   <= RESP;
                    end
                end
                WRITE:   state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register so an async reset drops them at once.
    assign req_ready      = (state == IDLE);
    assign memory_read    = (state == READ);
    assign memory_write   = (state == WRITE);
    assign resp_valid     = (state == RESP);
    assign resp_rdata     = (resp_valid && !write_q) ? rdata_q : 64'd0;
    assign memory_address = addr_q;
    assign write_data     = wdata_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: byte-array RAM, transaction-level reference model and
// per-cycle comparison of handshake, strobes, RAM traffic and responses.
module tb_memory_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic [63:0] memory_address;
    logic [63:0] write_data;
    logic        memory_write;
    logic        memory_read;
    logic [63:0] read_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    memory_access_unit dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .memory_address(memory_address), .write_data(write_data),
        .memory_write(memory_write), .memory_read(memory_read), .read_data(read_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        if (i == 0) return 8'h0C;
        if (i >= 1 && i <= 7) return 8'h00;
        if (i == 'h10) return 8'h80;
        if (i >= 'h21 && i <= 'h28) return 8'((i - 'h20) * 'h11);
        return 8'((i * 37 + 5) & 'hFF);
    endfunction

    // ---------------- RAM (4 KiB window, combinational read) ----------------
    logic [7:0] ram [0:4095];
    bit ram_loaded = 0;

    for (genvar g = 0; g < 8; g++) begin : g_rd
        logic [63:0] a;
        assign a = memory_address + 64'(g);
        assign read_data[8*g +: 8] = memory_read ? ram[a[11:0]] : 8'hxx;
    end

    always @(posedge clock) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
            ram_loaded <= 1;
        end else if (memory_write) begin
            for (int i = 0; i < 8; i++) begin
                logic [63:0] wa;
                wa = memory_address + 64'(i);
                ram[wa[11:0]] <= write_data[8*i +: 8];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [0:4095];
    bit          ref_loaded = 0;
    bit          pend_valid = 0;
    bit          p_write, p_signed;
    logic [1:0]  p_size;
    logic [63:0] p_addr, p_wdata;
    int          p_acc;
    int          acc_cnt = 0, last_acc = 0;
    int          rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, last_resp_cyc = 0;
    logic [63:0] last_rdata = 0, last_wdata = 0;

    function automatic logic [63:0] ref_read(input logic [63:0] a, input int n, input bit sgn);
        logic [63:0] v;
        logic [63:0] ea;
        v = 0;
        for (int i = 0; i < n; i++) begin
            ea = a + 64'(i);
            v[8*i +: 8] = ref_mem[ea[11:0]];
        end
        if (sgn && n < 8 && v[8*n-1]) begin
            for (int b = 8 * n; b < 64; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    bit          exp_ready, exp_rd, exp_wr, exp_resp;
    int          ph, nbytes;
    logic [63:0] exp_wd, ea;

    always @(negedge clock) begin
        if (!ref_loaded) begin
            for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
            ref_loaded = 1;
        end
        if (reset) begin
            pend_valid = 0;
        end else begin
            exp_ready = !pend_valid;
            exp_rd = 0; exp_wr = 0; exp_resp = 0;
            if (pend_valid) begin
                ph = cyc - p_acc;
                if (p_write && p_size == 2'd3) begin
                    exp_wr = (ph == 1); exp_resp = (ph == 2);
                end else if (p_write) begin
                    exp_rd = (ph == 1); exp_wr = (ph == 2); exp_resp = (ph == 3);
                end else begin
                    exp_rd = (ph == 1); exp_resp = (ph == 2);
                end
            end
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("memory_read", 64'(memory_read), 64'(exp_rd));
            check("memory_write", 64'(memory_write), 64'(exp_wr));
            check("resp_valid", 64'(resp_valid), 64'(exp_resp));
            if (exp_rd || exp_wr) check("memory_address", memory_address, p_addr);
            if (exp_wr) begin
                nbytes = 1 << p_size;
                exp_wd = ref_read(p_addr, 8, 1'b0);
                for (int i = 0; i < nbytes; i++) exp_wd[8*i +: 8] = p_wdata[8*i +: 8];
                check("write_data", write_data, exp_wd);
                for (int i = 0; i < 8; i++) begin
                    ea = p_addr + 64'(i);
                    ref_mem[ea[11:0]] = exp_wd[8*i +: 8];
                end
            end
            if (exp_resp) begin
                check("resp_rdata", resp_rdata,
                      p_write ? 64'd0 : ref_read(p_addr, 1 << p_size, p_signed && p_size != 2'd3));
                pend_valid = 0;
            end
            if (memory_read) rd_cnt++;
            if (memory_write) begin wr_cnt++; last_wdata = write_data; end
            if (resp_valid) begin resp_cnt++; last_rdata = resp_rdata; last_resp_cyc = cyc; end
            if (exp_ready && req_valid) begin
                pend_valid = 1;
                p_write = req_write; p_size = req_size; p_signed = req_signed;
                p_addr = req_addr; p_wdata = req_wdata; p_acc = cyc;
                acc_cnt++; last_acc = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit w, input logic [1:0] s, input bit sg,
                         input logic [63:0] a, input logic [63:0] d, input bit wait_done);
        int start;
        start = acc_cnt;
        req_valid = 1; req_write = w; req_size = s; req_signed = sg;
        req_addr = a; req_wdata = d;
        for (int k = 0; k < 20 && acc_cnt == start; k++) begin @(posedge clock); #1; end
        req_valid = 0;
        check("accepted", 64'(acc_cnt - start), 64'd1);
        if (wait_done) begin
            for (int k = 0; k < 20 && pend_valid; k++) begin @(posedge clock); #1; end
            check("completed", 64'(pend_valid), 64'd0);
        end
    endtask

    int r0, w0, q0, first_acc, mism;

    initial begin
        reset = 0; req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0;
        #1 reset = 1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_strobes", {62'd0, memory_write, memory_read}, 64'd0);
        check("rst_memory_address", memory_address, 64'd0);
        check("rst_write_data", write_data, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        reset = 0;
        @(posedge clock); #1;

        // Doubleword load at 0
        r0 = rd_cnt;
        issue(0, 2'd3, 0, 64'h0, 64'h0, 1);
        check("dw_load_data", last_rdata, 64'h0000_0000_0000_000C);
        check("dw_load_reads", 64'(rd_cnt - r0), 64'd1);
        check("dw_load_latency", 64'(last_resp_cyc - last_acc), 64'd2);

        // Byte load signed / unsigned
        issue(0, 2'd0, 1, 64'h10, 64'h0, 1);
        check("byte_load_signed", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        issue(0, 2'd0, 0, 64'h10, 64'h0, 1);
        check("byte_load_unsigned", last_rdata, 64'h0000_0000_0000_0080);

        // Half store of 0xBEEF to unaligned 0x21
        w0 = wr_cnt;
        issue(1, 2'd1, 0, 64'h21, 64'hFFFF_FFFF_FFFF_BEEF, 1);
        check("half_store_writes", 64'(wr_cnt - w0), 64'd1);
        check("half_store_wdata", last_wdata, 64'h8877_6655_4433_BEEF);
        check("half_store_latency", 64'(last_resp_cyc - last_acc), 64'd3);
        issue(0, 2'd3, 0, 64'h21, 64'h0, 1);
        check("half_store_readback", last_rdata, 64'h8877_6655_4433_BEEF);
        check("byte_0x20_kept", 64'(ram[12'h020]), 64'hA5);
        check("byte_0x29_kept", 64'(ram[12'h029]), 64'hF2);

        // Doubleword store to 0x100
        r0 = rd_cnt; w0 = wr_cnt;
        issue(1, 2'd3, 0, 64'h100, 64'h0123_4567_89AB_CDEF, 1);
        check("dw_store_reads", 64'(rd_cnt - r0), 64'd0);
        check("dw_store_writes", 64'(wr_cnt - w0), 64'd1);
        check("dw_store_wdata", last_wdata, 64'h0123_4567_89AB_CDEF);
        check("dw_store_latency", 64'(last_resp_cyc - last_acc), 64'd2);
        check("dw_store_ram_lo", 64'(ram[12'h100]), 64'hEF);

        // req_valid held high: word store then word load
        r0 = acc_cnt;
        req_valid = 1; req_write = 1; req_size = 2'd2; req_signed = 0;
        req_addr = 64'h80; req_wdata = 64'h1111_2222_CAFE_F00D;
        for (int k = 0; k < 20 && acc_cnt == r0; k++) begin @(posedge clock); #1; end
        first_acc = last_acc;
        req_write = 0; req_signed = 1;
        for (int k = 0; k < 20 && acc_cnt == r0 + 1; k++) begin @(posedge clock); #1; end
        req_valid = 0;
        check("held_accepts", 64'(acc_cnt - r0), 64'd2);
        check("held_spacing", 64'(last_acc - first_acc), 64'd4);
        for (int k = 0; k < 20 && pend_valid; k++) begin @(posedge clock); #1; end
        check("held_load_data", last_rdata, 64'hFFFF_FFFF_CAFE_F00D);

        // Async reset in the WRITE cycle of a partial store
        q0 = resp_cnt;
        issue(1, 2'd1, 0, 64'h40, 64'h1234, 0);
        @(posedge clock); #1;
        check("pre_reset_write", 64'(memory_write), 64'd1);
        #1 reset = 1;
        #1;
        check("reset_drops_write", 64'(memory_write), 64'd0);
        check("reset_ready", 64'(req_ready), 64'd1);
        @(posedge clock); #1;
        reset = 0;
        repeat (4) @(posedge clock);
        #1;
        check("reset_no_resp", 64'(resp_cnt - q0), 64'd0);
        check("reset_byte_0x40", 64'(ram[12'h040]), 64'(init_byte('h40)));
        check("reset_byte_0x41", 64'(ram[12'h041]), 64'(init_byte('h41)));
        check("ready_after_reset", 64'(req_ready), 64'd1);

        mism = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) mism++;
        check("ram_vs_model", 64'(mism), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Load/store initiator that sits between the CPU datapath and the byte-addressed 64-bit RAM. It accepts one load or store request at a time over a valid/ready handshake and drives the RAM's memory_address, write_data, memory_write and memory_read pins. Loads return sign- or zero-extended byte, half, word or doubleword results. Stores narrower than a doubleword use a read-modify-write, because the RAM always writes 8 bytes.

## Interface
- Parameters: none. All address and data widths are fixed at 64 bits.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces the block to IDLE immediately.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; equals (state == IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = doubleword.
- req_signed  in  1  sign-extend the load result; ignored for stores and for size 3.
- req_addr  in  64  byte address. Any alignment is allowed.
- req_wdata  in  64  store data; the low 8·2^size bits are used.
- resp_valid  out  1  one-cycle pulse marking completion of a load or store.
- resp_rdata  out  64  extended load data, valid while resp_valid=1 for loads; 0 for stores.
- memory_address  out  64  address to the RAM.
- write_data  out  64  data to the RAM, little-endian; byte 0 lands at memory_address.
- memory_write  out  1  RAM write strobe; the RAM commits 8 bytes on the rising edge.
- memory_read  out  1  RAM read enable.
- read_data  in  64  combinational RAM read data; X whenever memory_read=0.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- Transitions:
  - IDLE goes to READ when req_valid is high, except for a doubleword store, which goes to WRITE.
  - READ goes to RESP for a load, or to WRITE for a store.
  - WRITE goes to RESP.
  - RESP goes to IDLE.
- Accept: when req_valid=1 in IDLE, latch addr_q, wdata_q, size_q, signed_q and write_q. Request inputs are ignored outside IDLE.
- memory_read = (state == READ). memory_write = (state == WRITE). The two are never high together.
- memory_address = addr_q. write_data = wdata_q.
- Let n = 2^size_q bytes.
- Load, at the end of READ: rdata_q takes read_data[8n-1:0]. Bits above 8n are filled with read_data[8n-1] if signed_q, otherwise 0.
- Partial store, at the end of READ: wdata_q becomes {read_data[63:8n], wdata_q[8n-1:0]}. Bytes addr+n through addr+7 are therefore rewritten with their old values.
- Doubleword store: READ is skipped and wdata_q is written unchanged.
- RESP: resp_valid=1. resp_rdata = rdata_q for a load, 0 for a store.
- read_data is sampled only at the end of a READ cycle. It is never sampled while memory_read=0.
- Reset values:
  - state = IDLE, so req_ready=1.
  - resp_valid=0, memory_write=0, memory_read=0.
  - memory_address=0, write_data=0, resp_rdata=0.
  - All internal registers are 0.
- Reset mid-operation: the strobes drop asynchronously and the transaction is discarded with no response. A WRITE cycle cut off by reset before its clock edge must not commit to the RAM.
- Address arithmetic wraps modulo 2^64. The RAM decodes only address bits [49:0].

## Timing
Cycle N is the IDLE cycle in which req_valid=1 (accepted at the end of N).
- Load: READ in N+1, resp_valid in N+2, req_ready high again in N+3. Latency is 2 cycles; throughput is one request per 3 cycles.
- Doubleword store: WRITE in N+1, so the RAM is updated at the N+1/N+2 edge. resp_valid in N+2, IDLE in N+3.
- Partial store: READ in N+1, WRITE in N+2, resp_valid in N+3, IDLE in N+4.
- A req_valid held high through RESP is accepted on the first IDLE cycle after it, not earlier. There are no back-to-back accepts.
- There is no response backpressure. The requester must take resp_valid when it pulses.

## Test plan
- Reset, then a doubleword load at address 0 with RAM bytes 0..7 = 0x0C, 0, 0, 0, 0, 0, 0, 0 → resp_rdata = 0x000000000000000C at cycle N+2, and memory_read high only in cycle N+1.
- Byte load at address 0x10 holding 0x80, first with req_signed=1 and then with req_signed=0 → 0xFFFFFFFFFFFFFF80, then 0x0000000000000080.
- Half store of 0xBEEF to 0x21 over RAM bytes 0x21..0x28 = 0x11..0x88 → a single write of 0x887766554433BEEF. A subsequent doubleword load at 0x21 returns the same value, and the bytes at 0x20 and 0x29 are unchanged.
- Doubleword store of 0x0123456789ABCDEF to 0x100 → memory_write high for exactly one cycle (N+1), memory_read never high, resp_valid at N+2.
- req_valid held high continuously for a word store followed by a word load → accepts are spaced 4 cycles apart, and req_ready=0 in every non-IDLE cycle.
- Assert reset asynchronously mid-cycle during WRITE of a partial store → memory_write falls before the next clock edge, the RAM contents are unchanged, no resp_valid is produced, and req_ready=1 after reset releases.
